// File: rtl/timer_scheduler.sv
// -----------------------------------------------------------------------------
// timer_scheduler
//   Shares one countdown timer and the time_parameters lookup between
//   alarm-side requesters (index 0 = main alarm FSM, highest priority;
//   index 1 = arm-delay FSM). Requests are latched, the timer is granted by
//   fixed priority, the granted interval code is driven to time_parameters,
//   the returned seconds value is loaded and counted down, and the owner gets
//   a one-cycle done pulse. Also produces the one_hz / half_hz enables.
//
//   Optional build macro: TIMER_SCHED_PREEMPT_EN
//     defined   : a pending request from index 0 preempts another owner that
//                 is in FETCH/LOAD/COUNT; the preempted requester is re-queued
//                 and later restarts with a freshly fetched full interval.
//     undefined : strict run-to-completion.
//
//   Request protocol: req[i] is a single-cycle pulse with req_interval[i]
//   valid in the same cycle; there is no ready/backpressure, every pulse is
//   latched. grant is the one-hot owner (zero when idle) and done[i] is a
//   single-cycle completion pulse to the owner. cancel[i] withdraws a
//   pending request or aborts the owner's countdown without a done pulse.
//
// Ports
//   clock, reset     : system clock, asynchronous active-high reset
//   req, req_interval: request pulses and 2-bit interval codes per requester
//   cancel           : abort pulses per requester
//   interval_sel     : interval code to time_parameters
//   value            : seconds returned by time_parameters
//   grant, done      : one-hot owner, completion pulse
//   busy, remaining  : not-idle flag, seconds left (0 when idle)
//   one_hz_enable    : one-cycle pulse per elapsed second while counting
//   half_hz_enable   : level toggling on every one_hz_enable pulse
//   debug_state      : current FSM state
// -----------------------------------------------------------------------------
module timer_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int CLK_FREQ = 50000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_interval,
  input  logic [NUM_REQ-1:0]     cancel,
  output logic [1:0]             interval_sel,
  input  logic [3:0]             value,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [3:0]             remaining,
  output logic                   one_hz_enable,
  output logic                   half_hz_enable,
  output logic [2:0]             debug_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] COUNT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]      PRESCALE_LAST = PW'(CLK_FREQ - 1);
  localparam logic [NUM_REQ-1:0] ONE           = NUM_REQ'(1);

  logic [2:0]         state_q;
  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [1:0]         ivl_q [NUM_REQ];
  logic [OW-1:0]      owner_q;
  logic               fetch_wait_q;
  logic [3:0]         count_q;
  logic [PW-1:0]      prescaler_q;
  logic               half_q;
  logic [1:0]         sel_q;

  logic [NUM_REQ-1:0] eff_pending;
  logic [1:0]         eff_ivl [NUM_REQ];
  logic               arb_any;
  logic [OW-1:0]      arb_idx;
  logic               active;
  logic               take;
  logic               retrig;
  logic               abort;
  logic               preempt;
  logic               tick;

  // Requests arriving this cycle are visible to the arbiter immediately so an
  // idle scheduler grants on the cycle right after the pulse. req beats cancel.
  always_comb begin
    eff_pending = (pending_q & ~cancel) | req;
    for (int i = 0; i < NUM_REQ; i++) begin
      eff_ivl[i] = req[i] ? req_interval[2*i +: 2] : ivl_q[i];
    end
  end

  // Fixed priority: lowest pending index wins.
  always_comb begin
    arb_any = 1'b0;
    arb_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eff_pending[i]) begin
        arb_any = 1'b1;
        arb_idx = OW'(i);
      end
    end
  end

  assign active = (state_q == FETCH) || (state_q == LOAD) || (state_q == COUNT);
  assign take   = ((state_q == IDLE) || (state_q == DONE)) && arb_any;
  assign retrig = active && req[owner_q];
  assign abort  = active && cancel[owner_q] && !req[owner_q];

`ifdef TIMER_SCHED_PREEMPT_EN
  assign preempt = active && (owner_q != '0) && eff_pending[0] && !retrig && !abort;
`else
  assign preempt = 1'b0;
`endif

  // A second boundary only counts if the countdown is not being abandoned.
  assign tick = (state_q == COUNT) && (prescaler_q == PRESCALE_LAST) &&
                !retrig && !abort && !preempt;

  // Pending bits and stored interval codes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) ivl_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) begin
          pending_q[i] <= 1'b1;
          ivl_q[i]     <= req_interval[2*i +: 2];
        end else if (cancel[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
      // An owner's own request restarts its countdown instead of queueing.
      if (retrig) begin
        pending_q[owner_q] <= 1'b0;
      end else if (preempt) begin
        pending_q[0]       <= 1'b0;
        pending_q[owner_q] <= 1'b1;
      end else if (take) begin
        pending_q[arb_idx] <= 1'b0;
      end
    end
  end

  // Main FSM. DONE arbitrates directly so the next requester is granted on the
  // cycle after the done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      fetch_wait_q <= 1'b0;
      count_q      <= 4'd0;
      prescaler_q  <= '0;
      half_q       <= 1'b0;
      sel_q        <= 2'd0;
    end else begin
      if (tick) half_q <= ~half_q;
      case (state_q)
        IDLE, DONE: begin
          grant_q     <= '0;
          count_q     <= 4'd0;
          prescaler_q <= '0;
          state_q     <= IDLE;
          if (arb_any) begin
            grant_q      <= ONE << arb_idx;
            owner_q      <= arb_idx;
            sel_q        <= eff_ivl[arb_idx];
            fetch_wait_q <= 1'b1;
            state_q      <= FETCH;
          end
        end
        FETCH, LOAD, COUNT: begin
          if (abort) begin
            grant_q     <= '0;
            count_q     <= 4'd0;
            prescaler_q <= '0;
            state_q     <= IDLE;
          end else if (retrig) begin
            sel_q        <= eff_ivl[owner_q];
            prescaler_q  <= '0;
            fetch_wait_q <= 1'b1;
            state_q      <= FETCH;
          end else if (preempt) begin
            grant_q      <= ONE;
            owner_q      <= '0;
            sel_q        <= eff_ivl[0];
            prescaler_q  <= '0;
            fetch_wait_q <= 1'b1;
            state_q      <= FETCH;
          end else begin
            case (state_q)
              FETCH: begin
                // Hold two cycles so the looked-up value has settled by LOAD.
                if (fetch_wait_q) fetch_wait_q <= 1'b0;
                else              state_q      <= LOAD;
              end
              LOAD: begin
                count_q     <= value;
                prescaler_q <= '0;
                state_q     <= (value == 4'd0) ? DONE : COUNT;
              end
              default: begin
                if (prescaler_q == PRESCALE_LAST) begin
                  prescaler_q <= '0;
                  if (count_q != 4'd0) count_q <= count_q - 4'd1;
                  if (count_q <= 4'd1) state_q <= DONE;
                end else begin
                  prescaler_q <= prescaler_q + PW'(1);
                end
              end
            endcase
          end
        end
        default: begin
          grant_q <= '0;
          count_q <= 4'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign interval_sel   = sel_q;
  assign grant          = grant_q;
  assign done           = (state_q == DONE) ? grant_q : '0;
  assign busy           = (state_q != IDLE);
  assign remaining      = count_q;
  assign one_hz_enable  = tick;
  assign half_hz_enable = half_q;
  assign debug_state    = state_q;

endmodule

// File: tb/tb_timer_scheduler.sv
module tb_timer_scheduler;
  localparam int NUM_REQ  = 2;
  localparam int CLK_FREQ = 4;
  localparam int W        = 21;   // {requester index, 20-bit cycle number}

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req = '0;
  logic [2*NUM_REQ-1:0] req_interval = '0;
  logic [NUM_REQ-1:0]   cancel = '0;
  logic [1:0]           interval_sel;
  logic [3:0]           value = 4'd0;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic [3:0]           remaining;
  logic                 one_hz_enable;
  logic                 half_hz_enable;
  logic [2:0]           debug_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hz_total  = 0;
  int hz_window = 0;
  bit trace_en  = 1'b0;

  logic [3:0]   param_tbl [4];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [3:0]   rem_trace[$];

  timer_scheduler #(.NUM_REQ(NUM_REQ), .CLK_FREQ(CLK_FREQ)) dut (
    .clock(clock), .reset(reset), .req(req), .req_interval(req_interval),
    .cancel(cancel), .interval_sel(interval_sel), .value(value),
    .grant(grant), .done(done), .busy(busy), .remaining(remaining),
    .one_hz_enable(one_hz_enable), .half_hz_enable(half_hz_enable),
    .debug_state(debug_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // time_parameters stand-in: value follows interval_sel one cycle later.
  always @(posedge clock) value <= param_tbl[interval_sel];

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Monitor: samples mid-cycle, logs done events and one_hz pulses.
  always @(negedge clock) begin
    if (reset) begin
      hz_total = 0;
    end else begin
      checks++;
      if (!(grant == '0 || $onehot(grant))) begin
        errors++;
        $display("FAIL grant_onehot got %b required one-hot or zero (cycle %0d)", grant, cyc);
      end
      if (one_hz_enable) begin
        hz_total++;
        hz_window++;
      end
      if (done != '0) begin
        checks++;
        if (!$onehot(done) || done !== grant) begin
          errors++;
          $display("FAIL done_owner got done=%b grant=%b required done equal to one-hot grant", done, grant);
        end
        got_q.push_back({done[1], cyc[19:0]});
      end
      if (trace_en && (rem_trace.size() == 0 || rem_trace[rem_trace.size()-1] != remaining))
        rem_trace.push_back(remaining);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) next();
  endtask

  task automatic pulse_req(input int r, input logic [1:0] code);
    req[r] = 1'b1;
    req_interval[2*r +: 2] = code;
    next();
    req = '0;
  endtask

  function automatic logic [W-1:0] ev(input int idx, input int c);
    logic [W-1:0] e;
    e = {idx[0], c[19:0]};
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    run(3);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b required 00", grant); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b required 00", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL reset_remaining got %0d required 0", remaining); end
    checks++; if (half_hz_enable !== 1'b0) begin errors++; $display("FAIL reset_half_hz got %b required 0", half_hz_enable); end
    checks++; if (interval_sel !== 2'd0) begin errors++; $display("FAIL reset_interval_sel got %0d required 0", interval_sel); end
    checks++; if (one_hz_enable !== 1'b0) begin errors++; $display("FAIL reset_one_hz got %b required 0", one_hz_enable); end
    reset = 1'b0;
    run(2);
    checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL post_reset_idle got busy=%b grant=%b required 0/00", busy, grant); end
  endtask

  task automatic test_single_directed();
    logic [3:0] exp_rem[$];
    int g;
    exp_rem = '{4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    param_tbl[0] = 4'd3;
    exp_q.delete(); got_q.delete(); rem_trace.delete();
    hz_window = 0; trace_en = 1'b1;
    pulse_req(1, 2'd0);
    g = cyc;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL single_grant got %b required 10", grant); end
    exp_q.push_back(ev(1, g + 3 + 3*CLK_FREQ));
    run(3 + 3*CLK_FREQ + 3);
    trace_en = 1'b0;
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_done_count got %0d required %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL single_done got idx=%0d cyc=%0d required idx=%0d cyc=%0d", got_q[k][20], got_q[k][19:0], exp_q[k][20], exp_q[k][19:0]); end
    end
    checks++; if (hz_window != 3) begin errors++; $display("FAIL single_one_hz got %0d required 3", hz_window); end
    checks++;
    if (rem_trace.size() != exp_rem.size()) begin errors++; $display("FAIL single_remaining_len got %0d required %0d", rem_trace.size(), exp_rem.size()); end
    else foreach (exp_rem[k]) begin
      checks++;
      if (rem_trace[k] !== exp_rem[k]) begin errors++; $display("FAIL single_remaining[%0d] got %0d required %0d", k, rem_trace[k], exp_rem[k]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int r, g, v;
      logic [1:0] code;
      for (int j = 0; j < 4; j++) param_tbl[j] = 4'($urandom_range(0, 4));
      r = $urandom_range(0, 1);
      code = 2'($urandom_range(0, 3));
      v = int'(param_tbl[code]);
      exp_q.delete(); got_q.delete(); hz_window = 0;
      pulse_req(r, code);
      g = cyc;
      checks++; if (grant !== (2'b01 << r)) begin errors++; $display("FAIL rand_grant it=%0d got %b required %b", it, grant, 2'b01 << r); end
      checks++; if (interval_sel !== code) begin errors++; $display("FAIL rand_interval_sel it=%0d got %0d required %0d", it, interval_sel, code); end
      exp_q.push_back(ev(r, g + 3 + v*CLK_FREQ));
      run(3 + v*CLK_FREQ + 2);
      checks++;
      if (got_q.size() != 1) begin errors++; $display("FAIL rand_done_count it=%0d got %0d required 1", it, got_q.size()); end
      else if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL rand_done it=%0d got idx=%0d cyc=%0d required idx=%0d cyc=%0d", it, got_q[0][20], got_q[0][19:0], exp_q[0][20], exp_q[0][19:0]); end
      checks++; if (hz_window != v) begin errors++; $display("FAIL rand_one_hz it=%0d got %0d required %0d", it, hz_window, v); end
    end
    checks++; if (half_hz_enable !== hz_total[0]) begin errors++; $display("FAIL half_hz_parity got %b required %b", half_hz_enable, hz_total[0]); end
  endtask

  task automatic test_back_to_back();
    int g0, g1, d0, d1, v0, v1;
    logic [1:0] c0, c1;
    for (int j = 0; j < 4; j++) param_tbl[j] = 4'($urandom_range(1, 3));
    c0 = 2'($urandom_range(0, 3));
    c1 = 2'($urandom_range(0, 3));
    v0 = int'(param_tbl[c0]);
    v1 = int'(param_tbl[c1]);
    exp_q.delete(); got_q.delete();
    req = 2'b11;
    req_interval = {c1, c0};
    next();
    req = '0;
    g0 = cyc;
    d0 = g0 + 3 + v0*CLK_FREQ;
    g1 = d0 + 1;
    d1 = g1 + 3 + v1*CLK_FREQ;
    exp_q.push_back(ev(0, d0));
    exp_q.push_back(ev(1, d1));
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL b2b_first_grant got %b required 01", grant); end
    run(g1 - cyc);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL b2b_second_grant got %b required 10 (cycle %0d)", grant, cyc); end
    run(d1 - cyc + 2);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_done_count got %0d required %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_done[%0d] got idx=%0d cyc=%0d required idx=%0d cyc=%0d", k, got_q[k][20], got_q[k][19:0], exp_q[k][20], exp_q[k][19:0]); end
    end
  endtask

  task automatic test_zero_value();
    int g;
    param_tbl[2] = 4'd0;
    exp_q.delete(); got_q.delete(); hz_window = 0;
    pulse_req(0, 2'd2);
    g = cyc;
    run(6);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== ev(0, g + 3)) begin
      errors++;
      $display("FAIL zero_done got count=%0d first_cyc=%0d required one event at cycle %0d", got_q.size(), (got_q.size() > 0) ? int'(got_q[0][19:0]) : -1, g + 3);
    end
    checks++; if (hz_window != 0) begin errors++; $display("FAIL zero_one_hz got %0d required 0", hz_window); end
  endtask

  task automatic test_cancel();
    int g, c;
    param_tbl[2] = 4'd4;
    param_tbl[1] = 4'd1;
    exp_q.delete(); got_q.delete();
    pulse_req(1, 2'd2);
    g = cyc;
    run(g + 12 - cyc);
    c = cyc;
    checks++; if (remaining !== 4'd2) begin errors++; $display("FAIL cancel_pre_remaining got %0d required 2", remaining); end
    req = 2'b01; req_interval[1:0] = 2'd1; cancel = 2'b10;
    next();
    req = '0; cancel = '0;
    checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL cancel_idle got busy=%b grant=%b required 0/00", busy, grant); end
    checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL cancel_remaining got %0d required 0", remaining); end
    next();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cancel_next_grant got %b required 01", grant); end
    exp_q.push_back(ev(0, c + 2 + 3 + 1*CLK_FREQ));
    run(3 + CLK_FREQ + 3);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL cancel_done got count=%0d first=%h required one event %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_retrigger();
    logic [3:0] exp_rem[$];
    int g, r;
    exp_rem = '{4'd1, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    param_tbl[1] = 4'd2;
    param_tbl[3] = 4'd5;
    exp_q.delete(); got_q.delete(); rem_trace.delete();
    pulse_req(1, 2'd1);
    g = cyc;
    run(g + 8 - cyc);
    r = cyc;
    hz_window = 0; trace_en = 1'b1;
    pulse_req(1, 2'd3);
    exp_q.push_back(ev(1, r + 1 + 3 + 5*CLK_FREQ));
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL retrig_grant got %b required 10", grant); end
    run(r + 4 - cyc);
    checks++; if (remaining !== 4'd5) begin errors++; $display("FAIL retrig_reload got %0d required 5", remaining); end
    run(r + 1 + 3 + 5*CLK_FREQ + 3 - cyc);
    trace_en = 1'b0;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL retrig_done got count=%0d first=%h required one event %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
    end
    checks++; if (hz_window != 5) begin errors++; $display("FAIL retrig_one_hz got %0d required 5", hz_window); end
    checks++;
    if (rem_trace.size() != exp_rem.size()) begin errors++; $display("FAIL retrig_remaining_len got %0d required %0d", rem_trace.size(), exp_rem.size()); end
    else foreach (exp_rem[k]) begin
      checks++;
      if (rem_trace[k] !== exp_rem[k]) begin errors++; $display("FAIL retrig_remaining[%0d] got %0d required %0d", k, rem_trace[k], exp_rem[k]); end
    end
  endtask

`ifdef TIMER_SCHED_PREEMPT_EN
  task automatic test_preempt();
    int g, p, d0, g1, d1;
    param_tbl[0] = 4'd2;
    param_tbl[1] = 4'd1;
    exp_q.delete(); got_q.delete();
    pulse_req(1, 2'd0);
    g = cyc;
    run(g + 5 - cyc);
    p = cyc;
    pulse_req(0, 2'd1);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL preempt_grant got %b required 01", grant); end
    d0 = p + 1 + 3 + 1*CLK_FREQ;
    g1 = d0 + 1;
    d1 = g1 + 3 + 2*CLK_FREQ;
    exp_q.push_back(ev(0, d0));
    exp_q.push_back(ev(1, d1));
    run(d1 - cyc + 2);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL preempt_done_count got %0d required %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL preempt_done[%0d] got %h required %h", k, got_q[k], exp_q[k]); end
    end
  endtask
`endif

  task automatic test_reset_mid_count();
    int g;
    param_tbl[0] = 4'd3;
    param_tbl[1] = 4'd2;
    exp_q.delete(); got_q.delete();
    pulse_req(0, 2'd0);
    g = cyc;
    pulse_req(1, 2'd1);   // stays pending behind requester 0
    run(g + 6 - cyc);
    checks++; if (busy !== 1'b1 || remaining === 4'd0) begin errors++; $display("FAIL midreset_precondition got busy=%b remaining=%0d required counting", busy, remaining); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL midreset_grant got %b required 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b required 0", busy); end
    checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL midreset_remaining got %0d required 0", remaining); end
    checks++; if (half_hz_enable !== 1'b0) begin errors++; $display("FAIL midreset_half_hz got %b required 0", half_hz_enable); end
    run(2);
    reset = 1'b0;
    got_q.delete();
    run(8);
    checks++; if (busy !== 1'b0 || grant !== 2'b00 || got_q.size() != 0) begin errors++; $display("FAIL midreset_pending_lost got busy=%b grant=%b dones=%0d required 0/00/0", busy, grant, got_q.size()); end
  endtask

  initial begin
    for (int j = 0; j < 4; j++) param_tbl[j] = 4'd0;
    test_reset();
    test_single_directed();
    test_random();
    test_back_to_back();
    test_zero_value();
    test_cancel();
    test_retrigger();
`ifdef TIMER_SCHED_PREEMPT_EN
    test_preempt();
`endif
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
